blit_inner_seq: RTL and testbench
=================================

# blit_inner_seq

Inner-loop sequencer for the blitter. It holds the per-line inner pixel count, counts it down as pixel or phrase writes are accepted, and produces the `ocntena` strobe that decrements the outer line counter directly downstream. It decides completion from that counter's `outer0` flag. It sits between the blitter command registers (GPU writes) and the outer counter.

## Interface
Parameters:
- `CW`, 16: inner count width.

Ports:
- `sys_clk`  in  1  sole clock; all state changes on rising edge.
- `resetl`  in  1  asynchronous, active-low reset.
- `countld`  in  1  load inner reload register from `gpu_din[CW-1:0]`.
- `gpu_din`  in  32  GPU write data; bits [31:16] belong to the outer counter and are ignored here.
- `go`  in  1  start command; honoured only in IDLE.
- `step`  in  1  one pixel (pixel mode) or one phrase (phrase mode) write accepted this cycle.
- `phrase`  in  1  1 = phrase mode, 0 = pixel mode.
- `pixsize`  in  3  pixel size code 0..5 = 1/2/4/8/16/32 bpp; 6,7 treated as 5.
- `outer0`  in  1  outer counter at zero, from downstream.
- `icount`  out  CW  remaining pixels on current line.
- `istep`  out  7  pixels consumed by the next `step`.
- `inner0`  out  1  `icount == 0`.
- `ocntena`  out  1  one-cycle outer decrement strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reload register `ireload[CW-1:0]` is written on `countld` in any state. A write while busy takes effect at the next line reload.
- Pixels per phrase `ppp = 64 >> min(pixsize,5)`, giving 64..2.
- `istep = phrase ? min(icount, ppp) : (icount != 0)`. It is combinational from registered `icount`.
- States: IDLE, INNER, OUTER, CHECK, DONE.
- IDLE:
  - `go` with `ireload != 0`: `icount <= ireload`, go to INNER.
  - `go` with `ireload == 0`: go to DONE; no `ocntena`.
- INNER:
  - `step`: `icount <= icount - istep`.
  - If `icount - istep == 0`, go to OUTER.
  - No `step`: hold state and count.
- OUTER: `ocntena = 1` for exactly this cycle. Go to CHECK.
- CHECK (one cycle, lets the outer counter settle):
  - `outer0 = 1`: go to DONE.
  - `outer0 = 0`: `icount <= ireload`, go to INNER.
  - If `ireload == 0` here, go to DONE.
- DONE: `done = 1` for this cycle. Go to IDLE. `icount` retains 0.
- `step` outside INNER is ignored. `go` outside IDLE is ignored.
- Subtraction never underflows, because `istep <= icount` by construction.

## Timing
- Reset values: state IDLE, `icount = 0`, `ireload = 0`, `inner0 = 1`, `ocntena = 0`, `busy = 0`, `done = 0`. `istep` follows from `icount = 0`, so it is 0.
- `go` at edge n: `busy` high and `icount` loaded after edge n.
- Line-ending `step` sampled at edge n: `ocntena` high during cycle n+1, CHECK in n+2, then either INNER with reloaded count after edge n+2, or `done` high in cycle n+3.
- Line-to-line overhead: 2 idle cycles (OUTER, CHECK) per line.
- `resetl` low at any time, including mid-line: all state returns to reset values immediately; no `ocntena` or `done` is emitted.
- `countld` and `go` in the same cycle: `go` uses the old `ireload`. The new value applies to the next load.

## Structure
- Shared blitter package: state enum `inseq_state_t`, pixsize constants `PIX1..PIX32`, and the `PHRASE_BITS = 64` constant.
- One sub-module, `blit_step_calc`: combinational `ppp` and `istep` from `icount`, `phrase` and `pixsize`. It is reused later by the address-step logic.

## Test plan
- Reset mid-line: `ireload = 10`, `go`, 3 steps, drop `resetl` -> `icount = 0`, `busy = 0`, no `ocntena` pulse.
- Pixel mode:
  - Stimulus: `ireload = 5`; outer model loaded with 2; `go`; `step` every cycle.
  - Required: `ocntena` one cycle after the 5th step; reload to 5.
  - Required: second `ocntena` after 5 more steps.
  - Required: `outer0` then sends the block to DONE; exactly one `done` pulse, 3 cycles after the last step.
- Phrase mode, 16 bpp (`pixsize = 4`, `ppp = 4`):
  - Stimulus: `ireload = 10`.
  - Required: `istep` sequence 4, 4, 2; `icount` sequence 10, 6, 2, 0; `ocntena` after 3rd step.
- Zero count: `ireload = 0`, `go` -> `done` in the next cycle, `ocntena` never asserted.
- Mid-run reload: during line 1 of `ireload = 8`, `countld` with 3 -> line 2 starts with `icount = 3`; line 1 still completes 8 pixels.
- Ignored inputs:
  - `step` in IDLE/OUTER/CHECK -> no count change.
  - `go` while busy -> no restart.
  - `pixsize = 7` in phrase mode -> `ppp = 2`.

Source files
------------

// File: rtl/blit_inner_seq_pkg.sv
// Shared blitter definitions: inner sequencer states, pixel size codes and
// phrase geometry used by the step and address logic.
package blit_inner_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INNER = 3'd1,
      OUTER = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } inseq_state_t;

   localparam logic [2:0] PIX1  = 3'd0;
   localparam logic [2:0] PIX2  = 3'd1;
   localparam logic [2:0] PIX4  = 3'd2;
   localparam logic [2:0] PIX8  = 3'd3;
   localparam logic [2:0] PIX16 = 3'd4;
   localparam logic [2:0] PIX32 = 3'd5;

   localparam int PHRASE_BITS = 64;

   // Codes 6 and 7 are reserved and behave as 32 bpp.
   function automatic logic [2:0] pix_clamp(input logic [2:0] pixsize);
      return (pixsize > PIX32) ? PIX32 : pixsize;
   endfunction

endpackage

// File: rtl/blit_step_calc.sv
// Pixels consumed per accepted write: a whole phrase (capped at what is
// left on the line) in phrase mode, otherwise a single pixel.
module blit_step_calc #(
   parameter int CW = 16
) (
   input  logic [CW-1:0] icount,
   input  logic          phrase,
   input  logic [2:0]    pixsize,
   output logic [6:0]    ppp,
   output logic [6:0]    istep
);
   import blit_inner_seq_pkg::*;

   always_comb begin
      ppp   = 7'(PHRASE_BITS) >> pix_clamp(pixsize);
      istep = {6'd0, |icount};
      if (phrase)
         istep = (icount < CW'(ppp)) ? icount[6:0] : ppp;
   end

endmodule

// File: rtl/blit_inner_seq.sv
// Blitter inner-loop sequencer: counts pixels/phrases along a line, strobes
// the outer line counter at line end and finishes once that counter hits zero.
module blit_inner_seq #(
   parameter int CW = 16
) (
   input  logic          sys_clk,
   input  logic          resetl,
   input  logic          countld,
   input  logic [31:0]   gpu_din,
   input  logic          go,
   input  logic          step,
   input  logic          phrase,
   input  logic [2:0]    pixsize,
   input  logic          outer0,
   output logic [CW-1:0] icount,
   output logic [6:0]    istep,
   output logic          inner0,
   output logic          ocntena,
   output logic          busy,
   output logic          done
);
   import blit_inner_seq_pkg::*;

   inseq_state_t  state_q, state_d;
   logic [CW-1:0] icount_q, icount_d;
   logic [CW-1:0] ireload_q;
   logic [CW-1:0] icount_sub;
   logic [6:0]    unused_ppp;

   // Upper write-data bits feed the outer counter, not this block.
   generate
      if (CW < 32) begin : g_din_hi
         logic unused_din_hi;
         assign unused_din_hi = ^gpu_din[31:CW];
      end
   endgenerate

   blit_step_calc #(.CW(CW)) u_step_calc (
      .icount  (icount_q),
      .phrase  (phrase),
      .pixsize (pixsize),
      .ppp     (unused_ppp),
      .istep   (istep)
   );

   // istep never exceeds icount_q, so this cannot wrap.
   assign icount_sub = icount_q - CW'(istep);

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state_q   <= IDLE;
         icount_q  <= '0;
         ireload_q <= '0;
      end else begin
         state_q  <= state_d;
         icount_q <= icount_d;
         if (countld)
            ireload_q <= gpu_din[CW-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      icount_d = icount_q;
      ocntena  = 1'b0;
      done     = 1'b0;
      busy     = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (go) begin
               if (ireload_q != '0) begin
                  icount_d = ireload_q;
                  state_d  = INNER;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         INNER: begin
            if (step) begin
               icount_d = icount_sub;
               if (icount_sub == '0)
                  state_d = OUTER;
            end
         end
         OUTER: begin
            ocntena = 1'b1;
            state_d = CHECK;
         end
         // Extra cycle so outer0 reflects the decrement issued from OUTER.
         CHECK: begin
            if (outer0 || ireload_q == '0) begin
               state_d = DONE;
            end else begin
               icount_d = ireload_q;
               state_d  = INNER;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign icount = icount_q;
   assign inner0 = (icount_q == '0);

endmodule

// File: tb/tb_blit_inner_seq.sv
// Directed bench for blit_inner_seq with a small downstream outer-counter model.
module tb_blit_inner_seq;

   localparam int CW = 16;

   logic          sys_clk = 1'b0;
   logic          resetl  = 1'b0;
   logic          countld = 1'b0;
   logic [31:0]   gpu_din = '0;
   logic          go      = 1'b0;
   logic          step    = 1'b0;
   logic          phrase  = 1'b0;
   logic [2:0]    pixsize = 3'd0;
   logic          outer0;
   logic [CW-1:0] icount;
   logic [6:0]    istep;
   logic          inner0, ocntena, busy, done;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_oc   = 0;
   int n_done = 0;
   int oc0, dn0;

   // Outer line counter model: loads on request, decrements on ocntena.
   logic [15:0] ocnt = '0;
   logic        ocnt_ld = 1'b0;
   logic [15:0] ocnt_val = '0;
   assign outer0 = (ocnt == 16'd0);

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (ocnt_ld)                     ocnt <= ocnt_val;
      else if (ocntena && ocnt != 0)   ocnt <= ocnt - 16'd1;
   end

   always @(negedge sys_clk) begin
      if (ocntena) n_oc++;
      if (done)    n_done++;
   end

   blit_inner_seq #(.CW(CW)) dut (
      .sys_clk (sys_clk),
      .resetl  (resetl),
      .countld (countld),
      .gpu_din (gpu_din),
      .go      (go),
      .step    (step),
      .phrase  (phrase),
      .pixsize (pixsize),
      .outer0  (outer0),
      .icount  (icount),
      .istep   (istep),
      .inner0  (inner0),
      .ocntena (ocntena),
      .busy    (busy),
      .done    (done)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_inner(input logic [15:0] val);
      countld = 1'b1;
      gpu_din = {16'hA5C3, val};
      tick();
      countld = 1'b0;
   endtask

   task automatic load_outer(input logic [15:0] val);
      ocnt_ld  = 1'b1;
      ocnt_val = val;
      tick();
      ocnt_ld  = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_icount", 32'(icount), 0);
      chk("rst_inner0", 32'(inner0), 1);
      chk("rst_istep", 32'(istep), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ocntena", 32'(ocntena), 0);
      chk("rst_done", 32'(done), 0);
      resetl = 1'b1;
      tick();

      // Reset mid-line
      load_inner(16'd10);
      go = 1'b1; tick(); go = 1'b0;
      chk("mr_busy", 32'(busy), 1);
      chk("mr_icount_load", 32'(icount), 10);
      step = 1'b1; tick(); tick(); tick();
      chk("mr_icount_3", 32'(icount), 7);
      oc0 = n_oc; dn0 = n_done;
      #2 resetl = 1'b0;
      #1;
      chk("mr_icount_async", 32'(icount), 0);
      chk("mr_busy_async", 32'(busy), 0);
      step = 1'b0;
      tick(); tick();
      chk("mr_no_ocntena", 32'(n_oc - oc0), 0);
      chk("mr_no_done", 32'(n_done - dn0), 0);
      resetl = 1'b1;
      tick();

      // Pixel mode: 5 pixels per line, 2 lines
      phrase = 1'b0;
      load_inner(16'd5);
      load_outer(16'd2);
      oc0 = n_oc; dn0 = n_done;
      go = 1'b1; tick(); go = 1'b0;
      chk("px_icount_load", 32'(icount), 5);
      chk("px_istep", 32'(istep), 1);
      step = 1'b1;
      tick(); tick(); tick(); tick();
      chk("px_icount_4", 32'(icount), 1);
      chk("px_no_oc_early", 32'(ocntena), 0);
      tick();
      chk("px_oc1", 32'(ocntena), 1);
      chk("px_inner0", 32'(inner0), 1);
      tick();  // CHECK; step still high and must be ignored
      chk("px_check_oc", 32'(ocntena), 0);
      chk("px_check_icount", 32'(icount), 0);
      chk("px_check_busy", 32'(busy), 1);
      tick();
      chk("px_reload", 32'(icount), 5);
      tick(); tick(); tick(); tick();
      chk("px_l2_icount_4", 32'(icount), 1);
      tick();
      chk("px_oc2", 32'(ocntena), 1);
      step = 1'b0;
      tick();
      chk("px_check2_done", 32'(done), 0);
      tick();
      chk("px_done", 32'(done), 1);
      tick();
      chk("px_done_drop", 32'(done), 0);
      chk("px_idle_busy", 32'(busy), 0);
      chk("px_oc_total", 32'(n_oc - oc0), 2);
      chk("px_done_total", 32'(n_done - dn0), 1);

      // Step in IDLE is ignored
      step = 1'b1; tick(); step = 1'b0;
      chk("idle_step_icount", 32'(icount), 0);
      chk("idle_step_busy", 32'(busy), 0);

      // Phrase mode, 16 bpp
      phrase = 1'b1; pixsize = 3'd4;
      load_inner(16'd10);
      load_outer(16'd1);
      go = 1'b1; tick(); go = 1'b0;
      chk("ph_icount0", 32'(icount), 10);
      chk("ph_istep0", 32'(istep), 4);
      step = 1'b1; tick();
      chk("ph_icount1", 32'(icount), 6);
      chk("ph_istep1", 32'(istep), 4);
      tick();
      chk("ph_icount2", 32'(icount), 2);
      chk("ph_istep2", 32'(istep), 2);
      chk("ph_oc_not_yet", 32'(ocntena), 0);
      tick();
      chk("ph_icount3", 32'(icount), 0);
      chk("ph_oc", 32'(ocntena), 1);
      step = 1'b0;
      tick(); tick();
      chk("ph_done", 32'(done), 1);
      tick();

      // Zero count
      load_inner(16'd0);
      oc0 = n_oc;
      go = 1'b1; tick(); go = 1'b0;
      chk("z_done", 32'(done), 1);
      chk("z_busy", 32'(busy), 1);
      tick();
      chk("z_idle", 32'(busy), 0);
      chk("z_no_oc", 32'(n_oc - oc0), 0);

      // Mid-run reload
      phrase = 1'b0;
      load_inner(16'd8);
      load_outer(16'd2);
      go = 1'b1; tick(); go = 1'b0;
      chk("ml_icount_load", 32'(icount), 8);
      step = 1'b1; tick(); tick();
      countld = 1'b1; gpu_din = 32'h0000_0003;
      tick();
      countld = 1'b0;
      chk("ml_icount_3", 32'(icount), 5);
      tick(); tick(); tick(); tick();
      chk("ml_icount_7", 32'(icount), 1);
      chk("ml_busy_7", 32'(busy), 1);
      tick();
      chk("ml_oc", 32'(ocntena), 1);
      step = 1'b0;
      tick(); tick();
      chk("ml_line2_icount", 32'(icount), 3);
      step = 1'b1; tick(); tick(); tick();
      chk("ml_line2_oc", 32'(ocntena), 1);
      step = 1'b0;
      tick(); tick();
      chk("ml_done", 32'(done), 1);
      tick();

      // go while busy, clamped pixsize, countld+go together
      load_inner(16'd4);
      load_outer(16'd1);
      go = 1'b1; tick(); go = 1'b0;
      step = 1'b1; tick(); step = 1'b0;
      chk("gb_icount", 32'(icount), 3);
      load_inner(16'd9);
      go = 1'b1; tick(); go = 1'b0;
      chk("gb_no_restart", 32'(icount), 3);
      phrase = 1'b1; pixsize = 3'd0;
      #1 chk("ps0_istep", 32'(istep), 3);
      pixsize = 3'd7;
      #1 chk("ps7_istep", 32'(istep), 2);
      step = 1'b1; tick();
      chk("ps7_icount", 32'(icount), 1);
      chk("ps7_istep_tail", 32'(istep), 1);
      tick(); step = 1'b0;
      chk("ps7_oc", 32'(ocntena), 1);
      tick(); tick();
      chk("gb_done", 32'(done), 1);
      tick();

      // countld and go in the same cycle: go sees the old value (9)
      phrase = 1'b0;
      load_outer(16'd1);
      countld = 1'b1; gpu_din = 32'h0000_0006; go = 1'b1;
      tick();
      countld = 1'b0; go = 1'b0;
      chk("cg_old_reload", 32'(icount), 9);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
